gru_seq_driver: RTL and testbench
=================================

# gru_seq_driver

Sequence driver for the GRU hidden layer. It buffers a STEP-long input sequence, presents one xt per timestep with a one-cycle `en` strobe, and waits for the hidden layer's `h_finish`. It captures each resulting h into a readable history buffer and reports completion or timeout. The block sits between the host/load logic and the hidden layer, driving the hidden layer's input side and consuming its result side.

## Interface
Parameters:
- INPUTDIMEN, 4, elements per xt
- CELLNUM, 4, elements per h
- DATABIT, 16, bits per element
- STEP, 10, timesteps per sequence
- AW, 4, buffer address width; must satisfy 2^AW >= STEP
- TIMEOUT, 255, maximum wait cycles per handshake

Ports (XTNUM = INPUTDIMEN*DATABIT, HTNUM = CELLNUM*DATABIT):
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sequence; honoured only when idle
- x_wr_en  in  1  write one xt into the input buffer
- x_wr_addr  in  AW  input buffer address
- x_wr_data  in  XTNUM  xt word to store
- en  out  1  one-cycle compute strobe to the hidden layer
- xt  out  XTNUM  current timestep input; held stable between strobes
- h_finish  in  1  hidden-layer result-valid level
- h  in  HTNUM  hidden-layer state output
- grad_finish  in  1  gradient-valid level
- step_idx  out  AW  timestep currently in flight
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: sequence completed
- timeout_err  out  1  sticky handshake-timeout flag
- h_rd_addr  in  AW  history buffer read address
- h_rd_data  out  HTNUM  captured h at h_rd_addr

## Operation
- Storage: xbuf[STEP] of XTNUM bits and hbuf[STEP] of HTNUM bits. Contents are not cleared by reset.
- xbuf write happens when x_wr_en=1, busy=0 and x_wr_addr<STEP. All other writes are ignored.
- h_rd_data is registered with 1-cycle latency. An address >= STEP returns 0.
- Edge detect: h_rise = h_finish & ~h_finish_d and g_rise = grad_finish & ~grad_finish_d, where both _d are registered copies of the inputs. Both inputs are levels, so only rising edges count.
- FSM states: IDLE, WAIT_H, WAIT_G, with these transitions:
  - IDLE + start: step_idx<=0, xt<=xbuf[0], en<=1, busy<=1, timeout_err<=0, wait counter<=0, then WAIT_H.
  - WAIT_H + h_rise: hbuf[step_idx]<=h.
    - If step_idx<STEP-1: step_idx++, xt<=xbuf[step_idx+1], en<=1, counter<=0.
    - Else: go to WAIT_G (macro on) or finish (macro off).
  - WAIT_G + g_rise: finish.
  - Finish: done<=1 for one cycle, busy<=0, step_idx holds STEP-1, then IDLE.
  - In WAIT_H/WAIT_G without an edge, the counter increments. When the counter reaches TIMEOUT: timeout_err<=1, busy<=0, no done, then IDLE.
- `en` deasserts the cycle after each assertion.
- Boundaries:
  - start while busy is ignored.
  - An edge and a timeout on the same cycle: the edge wins.
  - An edge present while in IDLE is ignored; h_finish_d still tracks the input.
  - timeout_err clears only on an accepted start or on rst.
- Reset (any state): state=IDLE. en, xt, step_idx, busy, done, timeout_err, h_rd_data, counter and edge registers all go to 0. A sequence in flight is abandoned with no done.

## Timing
- start sampled at edge T0: en=1 and xt=xbuf[0] during cycle T0+1; busy=1 from T0+1.
- h_rise detected at edge Tk: hbuf written at Tk. The next en/xt are valid in cycle Tk+1, giving zero idle cycles between steps.
- done asserts in the cycle after the final qualifying edge.
- Timeout fires TIMEOUT cycles after the last en (or after the last h capture in WAIT_G).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- GRU_GRAD_WAIT_EN defined:
  - After the final h capture the FSM enters WAIT_G and waits for g_rise (with timeout) before done.
  - Total overhead is one extra handshake.
- GRU_GRAD_WAIT_EN undefined:
  - WAIT_G is not built and grad_finish is unused.
  - done follows the final h_rise directly.

## Test plan
- Load xbuf[i]=64'h0001_0002_0003_000i (i=0..9); start; model raises h_finish 20 cycles after each en and drops it 2 cycles later with h=i*3 -> exactly 10 en pulses with xt matching xbuf[i], hbuf[i]=i*3, one done pulse, busy low afterwards.
- Same run with macro on; grad_finish rises 5 cycles after the 10th h_finish -> done appears exactly 1 cycle after the grad_finish rise. With macro off -> done appears 1 cycle after the 10th h_rise.
- Hold h_finish low after the 3rd en, TIMEOUT=255 -> timeout_err=1 at 255 cycles, busy=0, no done. Next start clears timeout_err.
- Pulse start and x_wr_en(addr 0, data FFFF...) during busy -> no restart; xbuf[0] unchanged (verified on the next run).
- Assert rst at step 5 -> all outputs 0 next cycle and FSM idle. A following start runs a full 10-step sequence correctly.
- Read h_rd_addr=12 -> h_rd_data=0. Write x_wr_addr=11 -> ignored.

Source files
------------

// File: rtl/gru_seq_driver.sv
// Steps a buffered STEP-long xt sequence through the GRU hidden layer: one en strobe per step, next step on h_finish rise, zero idle cycles.
// All outputs registered; h history readable with 1-cycle latency; optional GRU_GRAD_WAIT_EN adds a final grad_finish handshake.
module gru_seq_driver #(
  parameter int INPUTDIMEN = 4,
  parameter int CELLNUM    = 4,
  parameter int DATABIT    = 16,
  parameter int STEP       = 10,
  parameter int AW         = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          x_wr_en,
  input  logic [AW-1:0]                 x_wr_addr,
  input  logic [INPUTDIMEN*DATABIT-1:0] x_wr_data,
  output logic                          en,
  output logic [INPUTDIMEN*DATABIT-1:0] xt,
  input  logic                          h_finish,
  input  logic [CELLNUM*DATABIT-1:0]    h,
  input  logic                          grad_finish,
  output logic [AW-1:0]                 step_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  input  logic [AW-1:0]                 h_rd_addr,
  output logic [CELLNUM*DATABIT-1:0]    h_rd_data
);

  localparam int XTNUM = INPUTDIMEN * DATABIT;
  localparam int HTNUM = CELLNUM * DATABIT;
  localparam int CW    = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   STEP_EXT = (AW+1)'(STEP);
  localparam logic [AW-1:0] LAST_IDX = AW'(STEP - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_H, S_WAIT_G} state_t;

  state_t            state, state_nxt;
  logic [XTNUM-1:0]  xbuf [STEP];
  logic [HTNUM-1:0]  hbuf [STEP];

  logic [CW-1:0]     cnt, cnt_nxt;
  logic              h_finish_d;
  logic              h_rise;
  logic              last_step;
  logic              cnt_last;
  logic              x_wr_ok;
  logic              h_rd_ok;
  logic              h_we;

  logic              en_nxt, busy_nxt, done_nxt, terr_nxt;
  logic [XTNUM-1:0]  xt_nxt;
  logic [AW-1:0]     step_nxt;

`ifdef GRU_GRAD_WAIT_EN
  logic              grad_finish_d;
  logic              g_rise;
  assign g_rise = grad_finish & ~grad_finish_d;
`else
  logic              unused_grad_finish;
  assign unused_grad_finish = grad_finish;
`endif

  assign h_rise    = h_finish & ~h_finish_d;
  assign last_step = (step_idx == LAST_IDX);
  assign cnt_last  = (cnt == CNT_LAST);
  assign x_wr_ok   = x_wr_en && !busy && ({1'b0, x_wr_addr} < STEP_EXT);
  assign h_rd_ok   = ({1'b0, h_rd_addr} < STEP_EXT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WAIT_H;
      S_WAIT_H: begin
        if (h_rise) begin
`ifdef GRU_GRAD_WAIT_EN
          if (last_step) state_nxt = S_WAIT_G;
`else
          if (last_step) state_nxt = S_IDLE;
`endif
        end else if (cnt_last) begin
          state_nxt = S_IDLE;
        end
      end
`ifdef GRU_GRAD_WAIT_EN
      S_WAIT_G: if (g_rise || cnt_last) state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; an edge is checked before the timeout so it wins a tie.
  always_comb begin
    en_nxt   = 1'b0;
    done_nxt = 1'b0;
    xt_nxt   = xt;
    step_nxt = step_idx;
    busy_nxt = busy;
    terr_nxt = timeout_err;
    cnt_nxt  = cnt;
    h_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          step_nxt = '0;
          xt_nxt   = xbuf[0];
          en_nxt   = 1'b1;
          busy_nxt = 1'b1;
          terr_nxt = 1'b0;
          cnt_nxt  = '0;
        end
      end
      S_WAIT_H: begin
        if (h_rise) begin
          h_we    = 1'b1;
          cnt_nxt = '0;
          if (!last_step) begin
            step_nxt = step_idx + 1'b1;
            xt_nxt   = xbuf[step_idx + 1'b1];
            en_nxt   = 1'b1;
          end else begin
`ifndef GRU_GRAD_WAIT_EN
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
`endif
          end
        end else if (cnt_last) begin
          terr_nxt = 1'b1;
          busy_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef GRU_GRAD_WAIT_EN
      S_WAIT_G: begin
        if (g_rise) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end else if (cnt_last) begin
          terr_nxt = 1'b1;
          busy_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      xt          <= '0;
      step_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      h_finish_d  <= 1'b0;
      h_rd_data   <= '0;
`ifdef GRU_GRAD_WAIT_EN
      grad_finish_d <= 1'b0;
`endif
    end else begin
      en          <= en_nxt;
      xt          <= xt_nxt;
      step_idx    <= step_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timeout_err <= terr_nxt;
      cnt         <= cnt_nxt;
      h_finish_d  <= h_finish;
      h_rd_data   <= h_rd_ok ? hbuf[h_rd_addr] : '0;
`ifdef GRU_GRAD_WAIT_EN
      grad_finish_d <= grad_finish;
`endif
    end
  end

  // Buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (x_wr_ok) xbuf[x_wr_addr] <= x_wr_data;
    if (h_we)    hbuf[step_idx]  <= h;
  end

endmodule

// File: tb/tb_gru_seq_driver.sv
// Directed bench for gru_seq_driver: full sequences, timeout, busy-time writes/starts, mid-run reset, history reads.
module tb_gru_seq_driver;

  localparam int INPUTDIMEN = 4;
  localparam int CELLNUM    = 4;
  localparam int DATABIT    = 16;
  localparam int STEP       = 10;
  localparam int AW         = 4;
  localparam int TIMEOUT    = 255;
  localparam int XTNUM      = INPUTDIMEN * DATABIT;
  localparam int HTNUM      = CELLNUM * DATABIT;
  localparam int BUDGET     = 1500;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              x_wr_en = 1'b0;
  logic [AW-1:0]     x_wr_addr = '0;
  logic [XTNUM-1:0]  x_wr_data = '0;
  logic              en;
  logic [XTNUM-1:0]  xt;
  logic              h_finish = 1'b0;
  logic [HTNUM-1:0]  h = '0;
  logic              grad_finish = 1'b0;
  logic [AW-1:0]     step_idx;
  logic              busy, done, timeout_err;
  logic [AW-1:0]     h_rd_addr = '0;
  logic [HTNUM-1:0]  h_rd_data;

  int checks = 0;
  int failures = 0;

  logic [XTNUM-1:0] xexp [STEP];

  int   cyc, n_en, n_done, xt_bad, gap_bad, en_cyc, last_raise, n_raise, g_raise, terr_cyc, done_cyc;
  logic first_busy, first_terr, terr_busy, budget_hit;

  gru_seq_driver #(
    .INPUTDIMEN(INPUTDIMEN), .CELLNUM(CELLNUM), .DATABIT(DATABIT),
    .STEP(STEP), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
    .en(en), .xt(xt), .h_finish(h_finish), .h(h), .grad_finish(grad_finish),
    .step_idx(step_idx), .busy(busy), .done(done), .timeout_err(timeout_err),
    .h_rd_addr(h_rd_addr), .h_rd_data(h_rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hidden-layer model: answers the first hang_after strobes 20 cycles later with h=idx*3 for 2 cycles,
  // raises grad_finish 5 cycles after the final h_finish, optionally pokes start/write at inject_cyc,
  // and optionally asserts rst 5 cycles into step rst_step (returning with rst still high).
  task automatic run_seq(input int hang_after, input int rst_step, input int inject_cyc);
    int raise_at, drop_at, gdrop, idle_run;
    raise_at = -1; drop_at = -1; gdrop = -1; idle_run = 0;
    cyc = 0; n_en = 0; n_done = 0; xt_bad = 0; gap_bad = 0; en_cyc = -1;
    last_raise = -100; n_raise = 0; g_raise = -100; terr_cyc = -1; done_cyc = -1;
    first_busy = 1'b0; first_terr = 1'b1; terr_busy = 1'b1; budget_hit = 1'b0;
    start = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      tick();
      start = 1'b0;
      x_wr_en = 1'b0;
      cyc++;
      if (cyc == 1) begin
        first_busy = busy;
        first_terr = timeout_err;
      end
      if (en) begin
        if (n_en >= STEP) xt_bad++;
        else if (xt !== xexp[n_en]) xt_bad++;
        if (n_en > 0 && cyc != last_raise + 1) gap_bad++;
        en_cyc = cyc;
        n_en++;
        raise_at = (n_en <= hang_after) ? cyc + 20 : -1;
      end
      if (cyc == raise_at) begin
        h_finish = 1'b1;
        h = HTNUM'((n_en - 1) * 3);
        last_raise = cyc;
        n_raise++;
        drop_at = cyc + 2;
      end
      if (cyc == drop_at) h_finish = 1'b0;
      if (n_raise == STEP && cyc == last_raise + 5) begin
        grad_finish = 1'b1;
        g_raise = cyc;
        gdrop = cyc + 2;
      end
      if (cyc == gdrop) grad_finish = 1'b0;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (timeout_err && terr_cyc < 0) begin
        terr_cyc = cyc;
        terr_busy = busy;
      end
      if (cyc == inject_cyc) begin
        start = 1'b1;
        x_wr_en = 1'b1;
        x_wr_addr = '0;
        x_wr_data = '1;
      end
      if (rst_step >= 0 && n_en == rst_step + 1 && cyc == en_cyc + 5) begin
        rst = 1'b1;
        break;
      end
      if (!busy) idle_run++;
      else idle_run = 0;
      if (idle_run >= 30) break;
      if (k == BUDGET - 1) budget_hit = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({en, busy, done, timeout_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: en/busy/done/terr=%b required 0000", {en, busy, done, timeout_err});
    end
    checks++;
    if (xt !== '0 || step_idx !== '0 || h_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_data: xt=%h step=%0d hrd=%h required all zero", xt, step_idx, h_rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic load_x;
    for (int i = 0; i < STEP; i++) begin
      xexp[i] = 64'h0001_0002_0003_0000 | 64'(i);
      x_wr_en = 1'b1;
      x_wr_addr = AW'(i);
      x_wr_data = xexp[i];
      tick();
    end
    // out-of-range address must not disturb anything
    x_wr_addr = AW'(11);
    x_wr_data = '1;
    tick();
    x_wr_en = 1'b0;
    tick();
  endtask

  task automatic check_full_run(input string tag);
    int ref_cyc;
`ifdef GRU_GRAD_WAIT_EN
    ref_cyc = g_raise;
`else
    ref_cyc = last_raise;
`endif
    checks++;
    if (budget_hit || n_en != STEP || n_done != 1) begin
      failures++;
      $display("FAIL %s_counts: en=%0d done=%0d budget_hit=%b required en=%0d done=1 budget_hit=0",
               tag, n_en, n_done, budget_hit, STEP);
    end
    checks++;
    if (xt_bad != 0 || gap_bad != 0) begin
      failures++;
      $display("FAIL %s_xt: xt_mismatches=%0d gap_errors=%0d required 0/0", tag, xt_bad, gap_bad);
    end
    checks++;
    if (done_cyc != ref_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing: done at cycle %0d required %0d", tag, done_cyc, ref_cyc + 1);
    end
    checks++;
    if (first_busy !== 1'b1 || busy !== 1'b0 || step_idx !== AW'(STEP - 1)) begin
      failures++;
      $display("FAIL %s_busy_step: first_busy=%b end_busy=%b step=%0d required 1/0/%0d",
               tag, first_busy, busy, step_idx, STEP - 1);
    end
  endtask

  task automatic test_sequence;
    logic [HTNUM-1:0] hexp;
    run_seq(STEP, -1, -1);
    check_full_run("seq");
    for (int i = 0; i < STEP; i++) begin
      h_rd_addr = AW'(i);
      tick();
      hexp = HTNUM'(i * 3);
      checks++;
      if (h_rd_data !== hexp) begin
        failures++;
        $display("FAIL hbuf_read[%0d]: got %h required %h", i, h_rd_data, hexp);
      end
    end
    h_rd_addr = AW'(12);
    tick();
    checks++;
    if (h_rd_data !== '0) begin
      failures++;
      $display("FAIL hbuf_read_oob: got %h required 0", h_rd_data);
    end
  endtask

  task automatic test_timeout;
    run_seq(2, -1, -1);
    checks++;
    if (budget_hit || n_en != 3 || n_done != 0) begin
      failures++;
      $display("FAIL timeout_counts: en=%0d done=%0d budget_hit=%b required 3/0/0", n_en, n_done, budget_hit);
    end
    checks++;
    if (terr_cyc - en_cyc != TIMEOUT || terr_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_timing: terr after %0d cycles busy=%b required %0d cycles busy=0",
               terr_cyc - en_cyc, terr_busy, TIMEOUT);
    end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_sticky: terr=%b busy=%b required 1/0", timeout_err, busy);
    end
  endtask

  task automatic test_busy_ignore;
    run_seq(STEP, -1, 60);
    checks++;
    if (first_terr !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL restart_clears_terr: first=%b end=%b required 0/0", first_terr, timeout_err);
    end
    check_full_run("busy_poke");
  endtask

  task automatic test_reset_mid;
    run_seq(STEP, 5, -1);
    tick();
    checks++;
    if ({en, busy, done, timeout_err} !== 4'b0000 || xt !== '0 || step_idx !== '0 || h_rd_data !== '0) begin
      failures++;
      $display("FAIL midrun_reset: en=%b busy=%b done=%b terr=%b xt=%h step=%0d hrd=%h required all zero",
               en, busy, done, timeout_err, xt, step_idx, h_rd_data);
    end
    checks++;
    if (n_done != 0 || n_en != 6) begin
      failures++;
      $display("FAIL midrun_progress: en=%0d done=%0d required 6/0", n_en, n_done);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || en !== 1'b0) begin
      failures++;
      $display("FAIL midrun_idle: busy=%b en=%b required 0/0", busy, en);
    end
    run_seq(STEP, -1, -1);
    check_full_run("after_reset");
  endtask

  initial begin
    test_reset();
    load_x();
    test_sequence();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
